// File: rtl/id_stage_fwd_p.sv
// id_stage_fwd_p: IF/ID pipeline register, write-through register file,
// load-use stall detection and operand forwarding for a 5-stage pipeline.
module id_stage_fwd_p #(
  parameter int DW = 32,
  parameter int AW = 5,
  parameter logic [DW-1:0] RESET_PC4 = 32'hffffffff,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [31:0]   if_inst,
  input  logic [DW-1:0] if_pc4,
  input  logic          if_valid,
  input  logic          flush,
  input  logic          use_rs,
  input  logic          use_rt,
  input  logic          ex_wreg,
  input  logic          ex_m2reg,
  input  logic [AW-1:0] ex_dest,
  input  logic [DW-1:0] ex_alu,
  input  logic          mem_wreg,
  input  logic          mem_m2reg,
  input  logic [AW-1:0] mem_dest,
  input  logic [DW-1:0] mem_alu,
  input  logic [DW-1:0] mem_load,
  input  logic          wb_wreg,
  input  logic [AW-1:0] wb_dest,
  input  logic [DW-1:0] wb_data,
  output logic [31:0]   id_inst,
  output logic [DW-1:0] id_pc4,
  output logic          id_valid,
  output logic [DW-1:0] id_a,
  output logic [DW-1:0] id_b,
  output logic [1:0]    fwda,
  output logic [1:0]    fwdb,
  output logic          stall,
  output logic          bubble,
  output logic [CW-1:0] stall_cnt,
  input  logic [AW-1:0] dbg_sel,
  output logic [DW-1:0] dbg_data
);
  logic [DW-1:0] r_rf [2**AW];
  logic [31:0]   r_inst;
  logic [DW-1:0] r_pc4;
  logic          r_valid;
  logic [CW-1:0] r_cnt;
  logic [AW-1:0] w_rs, w_rt;
  assign w_rs = r_inst[21+AW-1:21];
  assign w_rt = r_inst[16+AW-1:16];
  // operand 0 is rs, operand 1 is rt; EX ALU results outrank anything in MEM
  for (genvar i = 0; i < 2; i++) begin : g_op
    logic [AW-1:0] w_r;
    logic          w_u;
    logic [DW-1:0] w_rf;
    logic [1:0]    w_sel;
    logic [DW-1:0] w_val;
    assign w_r   = (i == 0) ? w_rs : w_rt;
    assign w_u   = (i == 0) ? use_rs : use_rt;
    assign w_rf  = (w_r == '0) ? '0 : (wb_wreg && wb_dest == w_r) ? wb_data : r_rf[w_r];
    assign w_sel = (!r_valid || !w_u || w_r == '0) ? 2'b00 :
                   (ex_wreg && !ex_m2reg && ex_dest == w_r) ? 2'b01 :
                   (mem_wreg && mem_dest == w_r) ? {1'b1, mem_m2reg} : 2'b00;
    assign w_val = (w_sel == 2'b01) ? ex_alu : (w_sel == 2'b10) ? mem_alu :
                   (w_sel == 2'b11) ? mem_load : w_rf;
  end
  assign fwda      = g_op[0].w_sel;
  assign fwdb      = g_op[1].w_sel;
  assign id_a      = g_op[0].w_val;
  assign id_b      = g_op[1].w_val;
  assign stall     = r_valid & ex_wreg & ex_m2reg & (ex_dest != '0) &
                     ((use_rs & (ex_dest == w_rs)) | (use_rt & (ex_dest == w_rt)));
  assign bubble    = stall | ~r_valid;
  assign id_inst   = r_inst;
  assign id_pc4    = r_pc4;
  assign id_valid  = r_valid;
  assign stall_cnt = r_cnt;
  assign dbg_data  = r_rf[dbg_sel];
  always_ff @(posedge clk or negedge rst)
    if (!rst)
      for (int k = 0; k < 2**AW; k++) r_rf[k] <= '0;
    else if (wb_wreg && wb_dest != '0)
      r_rf[wb_dest] <= wb_data;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_inst  <= '0;
      r_pc4   <= RESET_PC4;
      r_valid <= 1'b0;
    end else if (flush) begin
      r_inst  <= '0;
      r_valid <= 1'b0;
    end else if (!stall) begin
      r_inst  <= if_inst;
      r_pc4   <= if_pc4;
      r_valid <= if_valid;
    end
  always_ff @(posedge clk or negedge rst)
    if (!rst) r_cnt <= '0;
    else if (stall && r_cnt != '1) r_cnt <= r_cnt + 1'b1;
endmodule

// File: tb/tb_id_stage_fwd_p.sv
// tb_id_stage_fwd_p: scoreboard bench comparing id_stage_fwd_p against a behavioural model.
module tb_id_stage_fwd_p;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst = 1'b1;
  logic [31:0] if_inst, if_pc4, ex_alu, mem_alu, mem_load, wb_data;
  logic if_valid, flush, use_rs, use_rt, ex_wreg, ex_m2reg, mem_wreg, mem_m2reg, wb_wreg;
  logic [4:0] ex_dest, mem_dest, wb_dest, dbg_sel;
  logic [31:0] id_inst, id_pc4, id_a, id_b, dbg_data;
  logic id_valid, stall, bubble;
  logic [1:0] fwda, fwdb;
  logic [2:0] stall_cnt;

  id_stage_fwd_p #(.DW(32), .AW(5), .RESET_PC4(32'hffffffff), .CW(3)) dut (
    .clk(clk), .rst(rst), .if_inst(if_inst), .if_pc4(if_pc4), .if_valid(if_valid),
    .flush(flush), .use_rs(use_rs), .use_rt(use_rt), .ex_wreg(ex_wreg), .ex_m2reg(ex_m2reg),
    .ex_dest(ex_dest), .ex_alu(ex_alu), .mem_wreg(mem_wreg), .mem_m2reg(mem_m2reg),
    .mem_dest(mem_dest), .mem_alu(mem_alu), .mem_load(mem_load), .wb_wreg(wb_wreg),
    .wb_dest(wb_dest), .wb_data(wb_data), .id_inst(id_inst), .id_pc4(id_pc4),
    .id_valid(id_valid), .id_a(id_a), .id_b(id_b), .fwda(fwda), .fwdb(fwdb), .stall(stall),
    .bubble(bubble), .stall_cnt(stall_cnt), .dbg_sel(dbg_sel), .dbg_data(dbg_data));

  typedef struct {
    logic [31:0] inst, pc4, a, b, dbg;
    logic valid, stall, bubble;
    logic [1:0] fa, fb;
    logic [2:0] cnt;
  } exp_t;
  exp_t q[$];
  exp_t e_m;
  int n_chk = 0, n_fail = 0;

  logic [31:0] m_rf [32];
  logic [31:0] m_inst, m_pc4;
  logic m_valid, e_stall;
  int m_cnt;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk)
    if (q.size() > 0) begin
      e_m = q.pop_front();
      chk("id_inst", id_inst, e_m.inst);
      chk("id_pc4", id_pc4, e_m.pc4);
      chk("id_valid", 32'(id_valid), 32'(e_m.valid));
      chk("id_a", id_a, e_m.a);
      chk("id_b", id_b, e_m.b);
      chk("fwda", 32'(fwda), 32'(e_m.fa));
      chk("fwdb", 32'(fwdb), 32'(e_m.fb));
      chk("stall", 32'(stall), 32'(e_m.stall));
      chk("bubble", 32'(bubble), 32'(e_m.bubble));
      chk("stall_cnt", 32'(stall_cnt), 32'(e_m.cnt));
      chk("dbg_data", dbg_data, e_m.dbg);
    end

  function automatic logic [31:0] mk(input logic [4:0] s, input logic [4:0] t);
    return {6'd0, s, t, 16'h0};
  endfunction

  // Youngest producer of the register supplies the operand; loads still in EX cannot.
  task automatic fwd(input logic [4:0] r, input logic u, output logic [1:0] s, output logic [31:0] v);
    s = 2'b00;
    if (r == 0) v = 0;
    else if (wb_wreg && wb_dest == r) v = wb_data;
    else v = m_rf[r];
    if (m_valid && u && r != 0) begin
      if (ex_wreg && !ex_m2reg && ex_dest == r) begin s = 2'b01; v = ex_alu; end
      else if (mem_wreg && mem_dest == r) begin
        s = mem_m2reg ? 2'b11 : 2'b10;
        v = mem_m2reg ? mem_load : mem_alu;
      end
    end
  endtask

  task automatic mreset();
    m_inst = 0; m_pc4 = 32'hffffffff; m_valid = 0; m_cnt = 0;
    for (int k = 0; k < 32; k++) m_rf[k] = 0;
  endtask

  task automatic clr();
    if_inst = 0; if_pc4 = 0; if_valid = 0; flush = 0; use_rs = 0; use_rt = 0;
    ex_wreg = 0; ex_m2reg = 0; ex_dest = 0; ex_alu = 0;
    mem_wreg = 0; mem_m2reg = 0; mem_dest = 0; mem_alu = 0; mem_load = 0;
    wb_wreg = 0; wb_dest = 0; wb_data = 0; dbg_sel = 0;
  endtask

  task automatic cycle();
    exp_t e;
    logic [4:0] rs, rt;
    if (!rst) mreset();
    rs = m_inst[25:21];
    rt = m_inst[20:16];
    e_stall = m_valid && ex_wreg && ex_m2reg && ex_dest != 0 &&
              ((use_rs && ex_dest == rs) || (use_rt && ex_dest == rt));
    fwd(rs, use_rs, e.fa, e.a);
    fwd(rt, use_rt, e.fb, e.b);
    e.inst = m_inst; e.pc4 = m_pc4; e.valid = m_valid; e.stall = e_stall;
    e.bubble = e_stall || !m_valid; e.cnt = 3'(m_cnt); e.dbg = m_rf[dbg_sel];
    q.push_back(e);
    @(posedge clk);
    if (rst) begin
      if (wb_wreg && wb_dest != 0) m_rf[wb_dest] = wb_data;
      if (e_stall && m_cnt < 7) m_cnt++;
      if (flush) begin m_inst = 0; m_valid = 0; end
      else if (!e_stall) begin m_inst = if_inst; m_pc4 = if_pc4; m_valid = if_valid; end
    end
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    clr();
    rst = 1'b0;
    @(posedge clk); #1;
    cycle(); cycle();
    rst = 1'b1;
    wb_wreg = 1; wb_dest = 5; wb_data = 32'h1234; if_inst = mk(5, 0); if_pc4 = 4; if_valid = 1; cycle();
    clr(); use_rs = 1; dbg_sel = 5; wb_wreg = 1; wb_dest = 0; wb_data = 32'hffff;
    if_inst = mk(0, 0); if_pc4 = 8; if_valid = 1; cycle();
    clr(); use_rs = 1; if_inst = mk(0, 7); if_pc4 = 12; if_valid = 1; cycle();
    clr(); use_rt = 1; wb_wreg = 1; wb_dest = 7; wb_data = 32'haa; dbg_sel = 7;
    if_inst = mk(3, 3); if_pc4 = 16; if_valid = 1; cycle();
    clr(); dbg_sel = 7; use_rs = 1; use_rt = 1; ex_wreg = 1; ex_dest = 3; ex_alu = 32'h5555;
    if_inst = mk(3, 3); if_pc4 = 20; if_valid = 1; cycle();
    mem_wreg = 1; mem_dest = 3; mem_alu = 32'h6666; ex_alu = 32'h7777; if_inst = mk(4, 0); if_pc4 = 24; cycle();
    clr(); use_rs = 1; use_rt = 1; ex_wreg = 1; ex_m2reg = 1; ex_dest = 4;
    if_inst = mk(9, 9); if_pc4 = 28; if_valid = 1; cycle();
    clr(); use_rs = 1; mem_wreg = 1; mem_m2reg = 1; mem_dest = 4; mem_load = 32'hbeef;
    if_inst = mk(9, 9); if_pc4 = 32; if_valid = 1; cycle();
    clr(); use_rs = 1; ex_wreg = 1; ex_m2reg = 1; ex_dest = 9; flush = 1;
    if_inst = mk(1, 1); if_pc4 = 36; if_valid = 1; cycle();
    clr(); use_rs = 1; cycle();
    clr(); if_inst = mk(4, 0); if_pc4 = 40; if_valid = 1; cycle();
    clr(); use_rs = 1; ex_wreg = 1; ex_m2reg = 1; ex_dest = 4; ex_alu = 32'h1111;
    wb_wreg = 1; wb_dest = 6; wb_data = 32'h66; dbg_sel = 6;
    if_inst = mk(2, 2); if_pc4 = 44; if_valid = 1;
    repeat (11) cycle();
    rst = 1'b0; cycle(); cycle();
    rst = 1'b1;
    repeat (300) begin
      if_inst = $urandom;
      if_inst[25:21] = 5'($urandom_range(0, 7));
      if_inst[20:16] = 5'($urandom_range(0, 7));
      if_pc4 = $urandom; if_valid = ($urandom_range(0, 7) != 0); flush = ($urandom_range(0, 7) == 0);
      use_rs = 1'($urandom_range(0, 1)); use_rt = 1'($urandom_range(0, 1));
      ex_wreg = 1'($urandom_range(0, 1)); ex_m2reg = ($urandom_range(0, 2) == 0);
      ex_dest = 5'($urandom_range(0, 7)); ex_alu = $urandom;
      mem_wreg = 1'($urandom_range(0, 1)); mem_m2reg = ($urandom_range(0, 2) == 0);
      mem_dest = 5'($urandom_range(0, 7)); mem_alu = $urandom; mem_load = $urandom;
      wb_wreg = 1'($urandom_range(0, 1)); wb_dest = 5'($urandom_range(0, 7)); wb_data = $urandom;
      dbg_sel = 5'($urandom_range(0, 31));
      cycle();
    end
    repeat (2) @(negedge clk);
    chk("queue_drained", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/id_stage_fwd_p.md
# id_stage_fwd_p

Parametrised instruction-decode stage for the 5-stage pipelined CPU with forwarding. It holds the IF/ID pipeline register with stall and flush control, and owns a parametrised register file with WB write-through. It also detects load-use hazards, and generates and applies the operand forwarding selects, so EX receives final operand values. It sits between the fetch stage and the ID/EX register; an external control unit decodes `id_inst` and returns the operand-usage flags.

## Interface
- DW, 32, datapath and register width
- AW, 5, register address width; register count is 2**AW; rs = `id_inst[21+AW-1:21]`, rt = `id_inst[16+AW-1:16]`
- RESET_PC4, 32'hffffffff, reset value of `id_pc4`
- CW, 16, width of the saturating stall counter

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous active-low reset
- if_inst  in  32  fetched instruction
- if_pc4  in  DW  fetched PC+4
- if_valid  in  1  fetched slot holds a real instruction
- flush  in  1  taken branch/jump resolved; kill the IF/ID contents
- use_rs, use_rt  in  1 each  current `id_inst` reads rs / rt (from control unit)
- ex_wreg, ex_m2reg  in  1 each  EX-stage instruction writes a register / is a load
- ex_dest  in  AW  EX-stage destination register
- ex_alu  in  DW  EX-stage ALU result (combinational)
- mem_wreg, mem_m2reg  in  1 each  MEM-stage writes a register / is a load
- mem_dest  in  AW  MEM-stage destination register
- mem_alu  in  DW  MEM-stage ALU result
- mem_load  in  DW  MEM-stage load data
- wb_wreg  in  1  WB write enable
- wb_dest  in  AW  WB destination register
- wb_data  in  DW  WB write data
- id_inst  out  32  IF/ID instruction
- id_pc4  out  DW  IF/ID PC+4
- id_valid  out  1  IF/ID slot is a real instruction
- id_a, id_b  out  DW  forwarded operands (rs, rt)
- fwda, fwdb  out  2  select used: 00 regfile, 01 ex_alu, 10 mem_alu, 11 mem_load
- stall  out  1  load-use stall; freezes PC and IF/ID (wpcir)
- bubble  out  1  ID/EX must load a NOP this cycle
- stall_cnt  out  CW  saturating count of stall cycles
- dbg_sel  in  AW  debug register select
- dbg_data  out  DW  register `dbg_sel`, raw array value with no bypass

## Operation
- Register file has 2**AW entries. Register 0 reads 0 and ignores writes.
  - Write occurs at the clock edge when `wb_wreg` is high and `wb_dest` != 0.
  - Reads are combinational.
  - Write-through: when `wb_wreg` is high, `wb_dest` != 0 and `wb_dest` equals the read address, the read returns `wb_data`.
- Load-use hazard:
  - `stall` = `id_valid` & `ex_wreg` & `ex_m2reg` & (`ex_dest` != 0) & ((`use_rs` & `ex_dest`==rs) | (`use_rt` & `ex_dest`==rt)).
- fwda priority, computed per operand; fwdb is the same with rt / `use_rt`:
  - 01 when `ex_wreg` & !`ex_m2reg` & `ex_dest`==rs & rs != 0.
  - Otherwise, when `mem_wreg` & `mem_dest`==rs & rs != 0: 11 if `mem_m2reg`, else 10.
  - Otherwise 00.
  - Select is forced to 00 when the operand is unused or `id_valid`=0.
- `id_a` / `id_b` are the mux outputs chosen by `fwda` / `fwdb`.
- IF/ID update at each edge, in priority order:
  - `flush`: `id_inst` <= 0, `id_valid` <= 0, `id_pc4` holds.
  - else `stall`: all fields hold.
  - else: load `if_inst`, `if_pc4`, `if_valid`.
- `bubble` = `stall` | !`id_valid`.
- `stall_cnt` increments on each edge where `stall`=1 and saturates at all-ones.

## Timing
- Reset (`rst`=0, asynchronous):
  - `id_inst`=0, `id_pc4`=RESET_PC4, `id_valid`=0, `stall_cnt`=0, all registers 0.
  - Consequently `stall`=0, `bubble`=1, `fwda`=`fwdb`=00, `id_a`=`id_b`=0.
- Reset asserted mid-stall clears the stall immediately; there is no pending state.
- `stall`, `bubble`, `fwda`/`fwdb`, `id_a`/`id_b` and `dbg_data` are combinational, valid in the same cycle as their inputs.
- IF/ID has 1-cycle latency: the instruction presented on `if_inst` appears on `id_inst` after the next rising edge.
- A load-use stall lasts exactly 1 cycle. On the next cycle the load is in MEM and the operand selects 11.
- `flush` and `stall` in the same cycle: flush wins, and `stall_cnt` still increments.
- A WB write and an ID read of the same register in the same cycle return the new data.
- EX and MEM both matching the same register: EX wins (youngest producer).

## Test plan
- Reset, then write r5=0x1234 via WB → 1 cycle later, an instruction with rs=5 gives `id_a`=0x1234, `fwda`=00. WB to r0 → `id_a` for rs=0 stays 0.
- WB writing r7=0xAA while ID reads rt=7 in the same cycle → `id_b`=0xAA immediately (write-through); `dbg_data` for `dbg_sel`=7 shows 0xAA after the edge.
- ALU producer writes r3; consumer follows directly with rs=3, rt=3 → `fwda`=`fwdb`=01, `id_a`=`id_b`=`ex_alu`. One cycle later, MEM also has r3 while EX writes r3 → still 01.
- Load writes r4 (`ex_m2reg`=1), then `use_rs` with rs=4 → `stall`=1, `bubble`=1, IF/ID holds for 1 cycle, `stall_cnt` 0→1. Next cycle: `fwda`=11, `id_a`=`mem_load`.
- Stall and `flush` in the same cycle → next cycle `id_valid`=0, `id_inst`=0, `id_pc4` unchanged, `bubble`=1.
- Continuous load-use stall held for 2**CW+3 cycles (CW set small, e.g. 3) → `stall_cnt` saturates at 2**CW−1; drive `rst` low mid-run → all outputs return to reset values without waiting for a clock edge.
